// File: rtl/systolic_matmul3x3_if.sv
// Operand, result and start/done handshake bundle for the 3x3 systolic matrix multiplier.
// The master drives operands and start; the slave (the multiplier) returns results and status.
interface systolic_matmul3x3_if #(
    parameter int W = 5
);
    logic         start;
    logic [W-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic [W-1:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic [W-1:0] o1, o2, o3, o4, o5, o6, o7, o8, o9;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output a1, a2, a3, a4, a5, a6, a7, a8, a9,
        output b1, b2, b3, b4, b5, b6, b7, b8, b9,
        input  o1, o2, o3, o4, o5, o6, o7, o8, o9,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a1, a2, a3, a4, a5, a6, a7, a8, a9,
        input  b1, b2, b3, b4, b5, b6, b7, b8, b9,
        output o1, o2, o3, o4, o5, o6, o7, o8, o9,
        output busy,
        output done
    );
endinterface

// File: rtl/systolic_matmul3x3.sv
// Output-stationary 3x3 systolic matrix multiplier: C = A x B mod 2^W.
// Rows of A stream rightwards and columns of B stream downwards through nine MAC cells.
module systolic_matmul3x3 #(
    parameter int W = 5,
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_matmul3x3_if.slave  bus
);

    localparam int PW        = 2 * W;
    localparam int AW        = 2 * W + 2;
    localparam int LAST_STEP = 3 * (N - 1);
    localparam int SW        = $clog2(LAST_STEP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   step_r;
    logic            busy_r;
    logic            done_r;

    logic [W-1:0]    a_op_r    [N][N];
    logic [W-1:0]    b_op_r    [N][N];
    logic [W-1:0]    o_r       [N][N];

    logic [W-1:0]    a_feed_s  [N];
    logic [W-1:0]    b_feed_s  [N];
    logic [W-1:0]    a_west_s  [N][N];
    logic [W-1:0]    b_north_s [N][N];
    logic [PW-1:0]   prod_s    [N][N];
    logic [AW-1:0]   acc_r     [N][N];
    logic [W-1:0]    a_fwd_r   [N][N-1];
    logic [W-1:0]    b_fwd_r   [N-1][N];

    logic            clr_s;
    logic            en_s;

    assign clr_s = (state_r == IDLE) && bus.start;
    assign en_s  = (state_r == RUN);

    // Skewed edge feed: row i / column j sees operand k exactly at step i+k / j+k, zero otherwise.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_feed_s[i] = {W{1'b0}};
            b_feed_s[i] = {W{1'b0}};
            for (int k = 0; k < N; k++) begin
                a_feed_s[i] = a_feed_s[i] | ((int'(step_r) == i + k) ? a_op_r[i][k] : {W{1'b0}});
                b_feed_s[i] = b_feed_s[i] | ((int'(step_r) == i + k) ? b_op_r[k][i] : {W{1'b0}});
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_west_s[gi][gj] = a_feed_s[gi];
            end else begin : g_a_link
                assign a_west_s[gi][gj] = a_fwd_r[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_north_s[gi][gj] = b_feed_s[gj];
            end else begin : g_b_link
                assign b_north_s[gi][gj] = b_fwd_r[gi-1][gj];
            end
            assign prod_s[gi][gj] = {{W{1'b0}}, a_west_s[gi][gj]} * {{W{1'b0}}, b_north_s[gi][gj]};
        end
    end

    // PE array: accumulate during RUN and forward operands one cell right / down per step.
    always_ff @(posedge clk) begin
        if (rst || clr_s) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_r[i][j] <= {AW{1'b0}};
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N - 1; j++) begin
                    a_fwd_r[i][j] <= {W{1'b0}};
                    b_fwd_r[j][i] <= {W{1'b0}};
                end
            end
        end else if (en_s) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_r[i][j] <= acc_r[i][j] + {2'b00, prod_s[i][j]};
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N - 1; j++) begin
                    a_fwd_r[i][j] <= a_west_s[i][j];
                    b_fwd_r[j][i] <= b_north_s[j][i];
                end
            end
        end
    end

    // Control FSM: operand capture, step sequencing, result load and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            step_r  <= {SW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_op_r[i][j] <= {W{1'b0}};
                    b_op_r[i][j] <= {W{1'b0}};
                    o_r[i][j]    <= {W{1'b0}};
                end
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_op_r[0][0] <= bus.a1;
                        a_op_r[0][1] <= bus.a2;
                        a_op_r[0][2] <= bus.a3;
                        a_op_r[1][0] <= bus.a4;
                        a_op_r[1][1] <= bus.a5;
                        a_op_r[1][2] <= bus.a6;
                        a_op_r[2][0] <= bus.a7;
                        a_op_r[2][1] <= bus.a8;
                        a_op_r[2][2] <= bus.a9;
                        b_op_r[0][0] <= bus.b1;
                        b_op_r[0][1] <= bus.b2;
                        b_op_r[0][2] <= bus.b3;
                        b_op_r[1][0] <= bus.b4;
                        b_op_r[1][1] <= bus.b5;
                        b_op_r[1][2] <= bus.b6;
                        b_op_r[2][0] <= bus.b7;
                        b_op_r[2][1] <= bus.b8;
                        b_op_r[2][2] <= bus.b9;
                        step_r       <= {SW{1'b0}};
                        busy_r       <= 1'b1;
                        state_r      <= RUN;
                    end
                end
                RUN: begin
                    if (step_r == SW'(LAST_STEP)) begin
                        state_r <= FLUSH;
                    end else begin
                        step_r <= step_r + SW'(1);
                    end
                end
                FLUSH: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            o_r[i][j] <= acc_r[i][j][W-1:0];
                        end
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    step_r  <= {SW{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    step_r  <= {SW{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.o1   = o_r[0][0];
    assign bus.o2   = o_r[0][1];
    assign bus.o3   = o_r[0][2];
    assign bus.o4   = o_r[1][0];
    assign bus.o5   = o_r[1][1];
    assign bus.o6   = o_r[1][2];
    assign bus.o7   = o_r[2][0];
    assign bus.o8   = o_r[2][1];
    assign bus.o9   = o_r[2][2];
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_systolic_matmul3x3.sv
// Self-checking bench for systolic_matmul3x3: directed and random matrices against a plain matrix-product model.
module tb_systolic_matmul3x3;

    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;

    systolic_matmul3x3_if #(.W(W)) bus ();

    systolic_matmul3x3 #(.W(W), .N(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ma [3][3];
    logic [W-1:0] mb [3][3];
    int           exp_c [3][3];
    logic [W-1:0] o_obs [3][3];

    assign o_obs[0][0] = bus.o1;
    assign o_obs[0][1] = bus.o2;
    assign o_obs[0][2] = bus.o3;
    assign o_obs[1][0] = bus.o4;
    assign o_obs[1][1] = bus.o5;
    assign o_obs[1][2] = bus.o6;
    assign o_obs[2][0] = bus.o7;
    assign o_obs[2][1] = bus.o8;
    assign o_obs[2][2] = bus.o9;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ops(input logic [W-1:0] xa [3][3], input logic [W-1:0] xb [3][3]);
        bus.a1 = xa[0][0]; bus.a2 = xa[0][1]; bus.a3 = xa[0][2];
        bus.a4 = xa[1][0]; bus.a5 = xa[1][1]; bus.a6 = xa[1][2];
        bus.a7 = xa[2][0]; bus.a8 = xa[2][1]; bus.a9 = xa[2][2];
        bus.b1 = xb[0][0]; bus.b2 = xb[0][1]; bus.b3 = xb[0][2];
        bus.b4 = xb[1][0]; bus.b5 = xb[1][1]; bus.b6 = xb[1][2];
        bus.b7 = xb[2][0]; bus.b8 = xb[2][1]; bus.b9 = xb[2][2];
    endtask

    // Reference: textbook row-by-column product, reduced mod 2^W.
    task automatic compute_ref();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) s += int'(ma[i][k]) * int'(mb[k][j]);
                exp_c[i][j] = s % (1 << W);
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = W'($urandom_range(0, (1 << W) - 1));
                mb[i][j] = W'($urandom_range(0, (1 << W) - 1));
            end
        end
    endtask

    task automatic scramble_inputs();
        logic [W-1:0] ra [3][3];
        logic [W-1:0] rb [3][3];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ra[i][j] = W'($urandom);
                rb[i][j] = W'($urandom);
            end
        end
        drive_ops(ra, rb);
    endtask

    task automatic check_outputs(input string name);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                check_value($sformatf("%s_o%0d", name, 3 * i + j + 1), 32'(o_obs[i][j]), 32'(exp_c[i][j]));
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the done pulse (or after the next one if !hold).
    task automatic run_op(input string name, input bit hold, input bit scramble);
        int lat;
        int busy_cnt;
        compute_ref();
        drive_ops(ma, mb);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_value({name, "_busy_start"}, 32'(bus.busy), 32'd1);
        check_value({name, "_done_low"}, 32'(bus.done), 32'd0);
        bus.start = hold;
        if (scramble) scramble_inputs();
        busy_cnt = 1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (scramble) scramble_inputs();
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        check_value({name, "_latency"}, 32'(lat), 32'd8);
        check_value({name, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check_value({name, "_busy_end"}, 32'(bus.busy), 32'd0);
        check_outputs(name);
        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            check_value({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
            check_outputs({name, "_hold"});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
                exp_c[i][j] = 0;
            end
        end
        drive_ops(ma, mb);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        check_value("reset_busy", 32'(bus.busy), 32'd0);
        check_value("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin ma[i][j] = 5'd4; mb[i][j] = 5'd1; end
        run_op("uniform", 1'b0, 1'b0);
        check_value("uniform_o5_const", 32'(o_obs[1][1]), 32'd12);

        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
            ma[i][j] = W'(3 * i + j + 1);
            mb[i][j] = W'(3 * i + j + 1);
        end
        run_op("ordered", 1'b0, 1'b0);
        check_value("ordered_o1_const", 32'(o_obs[0][0]), 32'd30);
        check_value("ordered_o6_const", 32'(o_obs[1][2]), 32'd0);
        check_value("ordered_o9_const", 32'(o_obs[2][2]), 32'd22);

        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin ma[i][j] = 5'd31; mb[i][j] = 5'd31; end
        run_op("overflow", 1'b0, 1'b0);
        check_value("overflow_o9_const", 32'(o_obs[2][2]), 32'd3);

        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
            ma[i][j] = (i == j) ? 5'd1 : 5'd0;
            mb[i][j] = W'(3 * i + j + 1);
        end
        run_op("identity", 1'b0, 1'b0);

        fill_random();
        run_op("indep", 1'b0, 1'b1);

        fill_random();
        run_op("held_first", 1'b1, 1'b0);
        fill_random();
        run_op("held_second", 1'b0, 1'b0);

        fill_random();
        drive_ops(ma, mb);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) exp_c[i][j] = 0;
        check_outputs("abort");
        check_value("abort_busy", 32'(bus.busy), 32'd0);
        check_value("abort_done", 32'(bus.done), 32'd0);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dones++;
        end
        check_value("abort_no_done", 32'(dones), 32'd0);

        fill_random();
        run_op("after_reset", 1'b0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_op($sformatf("rand%0d", n), 1'b0, n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
